float_to_int_unit: RTL and testbench

Multi-cycle converter from the pipeline's 16-bit float format (sign [15], biased exponent [14:7], bias 127, 7-bit trailing mantissa [6:0], implicit leading 1) to a 16-bit two's-complement integer, truncating toward zero. It is the inverse of the existing integer-to-float path and serves `OPftoi` in the execute stage. Operands arrive on a valid/ready handshake. The magnitude is aligned by an iterative one-bit-per-cycle shifter. Results are held on an output valid/ready handshake until consumed.

---
 rtl/float_to_int_unit_if.sv | 25 ++
 rtl/float_to_int_unit.sv | 140 ++++++++++++++
 tb/tb_float_to_int_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/float_to_int_unit_if.sv
// Operand/result handshake bundle for the float-to-integer converter.
// Ports: in_valid/in_ready/in_word carry the 16-bit float operand;
//        out_valid/out_ready/out_word/out_sat/out_inexact carry the integer result.
interface float_to_int_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_sat;
    logic        out_inexact;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_sat, out_inexact
    );

    // The converter itself.
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_sat, out_inexact
    );
endinterface

// File: rtl/float_to_int_unit.sv
// Converts the 16-bit float (s|e[7:0] bias 127|m[6:0]) to a truncated 16-bit signed int.
// Latency: specials resolve on the accept edge; normals take |e-134|+1 further edges.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Ports: clk, reset (async, active-high), bus (slave side of float_to_int_unit_if).
module float_to_int_unit (
    input  logic               clk,
    input  logic               reset,
    float_to_int_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [15:0] mag_q;
    logic [2:0]  cnt_q;
    logic        dir_left_q;
    logic        sticky_q;
    logic        sign_q;
    logic [15:0] out_word_q;
    logic        out_sat_q;
    logic        out_inexact_q;
    logic        out_valid_q;

    logic        s_w;
    logic [7:0]  e_w;
    logic [6:0]  m_w;

    assign s_w = bus.in_word[15];
    assign e_w = bus.in_word[14:7];
    assign m_w = bus.in_word[6:0];

    // Decode of the incoming operand: special cases resolve straight to a result.
    logic        special_d;
    logic [15:0] spec_word_d;
    logic        spec_sat_d;
    logic        spec_inexact_d;
    logic [15:0] sat_word_d;
    logic        dir_left_d;
    logic [2:0]  cnt_d;

    always_comb begin
        special_d      = 1'b1;
        spec_word_d    = 16'h0000;
        spec_sat_d     = 1'b0;
        spec_inexact_d = 1'b0;
        sat_word_d     = s_w ? 16'h8000 : 16'h7FFF;
        if (e_w == 8'd0) begin
            // zero and denormals flush to zero, exact
        end else if (e_w < 8'd127) begin
            spec_inexact_d = 1'b1;              // |x| < 1 truncates to zero
        end else if (e_w == 8'd255 && m_w != 7'd0) begin
            spec_sat_d     = 1'b1;              // NaN
        end else if (e_w >= 8'd143) begin
            spec_word_d    = sat_word_d;        // infinity or out of range
            spec_sat_d     = 1'b1;
        end else if (e_w == 8'd142) begin
            // Only -32768 is representable at this exponent.
            if (s_w && m_w == 7'd0) begin
                spec_word_d = 16'h8000;
            end else begin
                spec_word_d = sat_word_d;
                spec_sat_d  = 1'b1;
            end
        end else begin
            special_d      = 1'b0;
        end
    end

    // For e in 127..141 the distance |e-134| is below 8, so it can be taken
    // modulo 8 from the low exponent bits alone (134 mod 8 == 6).
    assign dir_left_d = (e_w > 8'd134);
    assign cnt_d      = dir_left_d ? (e_w[2:0] - 3'd6) : (3'd6 - e_w[2:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mag_q         <= 16'h0000;
            cnt_q         <= 3'd0;
            dir_left_q    <= 1'b0;
            sticky_q      <= 1'b0;
            sign_q        <= 1'b0;
            out_word_q    <= 16'h0000;
            out_sat_q     <= 1'b0;
            out_inexact_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= s_w;
                        if (special_d) begin
                            out_word_q    <= spec_word_d;
                            out_sat_q     <= spec_sat_d;
                            out_inexact_q <= spec_inexact_d;
                            out_valid_q   <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            mag_q      <= {8'h00, 1'b1, m_w};
                            cnt_q      <= cnt_d;
                            dir_left_q <= dir_left_d;
                            sticky_q   <= 1'b0;
                            state_q    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt_q != 3'd0) begin
                        if (dir_left_q) begin
                            mag_q <= {mag_q[14:0], 1'b0};
                        end else begin
                            mag_q    <= {1'b0, mag_q[15:1]};
                            sticky_q <= sticky_q | mag_q[0];
                        end
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        out_word_q    <= sign_q ? (~mag_q + 16'd1) : mag_q;
                        out_sat_q     <= 1'b0;
                        out_inexact_q <= sticky_q;
                        out_valid_q   <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_word    = out_word_q;
    assign bus.out_sat     = out_sat_q;
    assign bus.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_float_to_int_unit.sv
// Randomized + directed bench for float_to_int_unit with a queue scoreboard.
// Results are predicted from the numeric value of the float (integer arithmetic)
// and compared by an independent monitor, including latency and hold behaviour.
module tb_float_to_int_unit;

    logic clk;
    logic reset;
    float_to_int_unit_if bus ();

    float_to_int_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] op;
        logic [15:0] w;
        logic        sat;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   consume_cyc = 0;
    logic force_low = 1'b1;
    logic prev_v = 1'b0;
    logic [15:0] held_word = 16'h0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Value-level reference: scale the significand by 2^(e-134), truncate, range-check.
    function automatic exp_t model(input logic [15:0] w);
        exp_t   x;
        int     e;
        int     m;
        int     k;
        longint sig;
        longint v;
        e = {24'd0, w[14:7]};
        m = {25'd0, w[6:0]};
        sig = 128 + m;
        x.op = w; x.w = 16'h0000; x.sat = 1'b0; x.inx = 1'b0; x.lat = 0; x.acc = 0;
        if (e == 0) begin
            x.w = 16'h0000;
        end else if (e == 255 && m != 0) begin
            x.sat = 1'b1;
        end else if (e == 255 || e >= 150) begin
            x.sat = 1'b1;
            x.w = w[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            k = e - 134;
            if (k >= 0) begin
                v = sig <<< k;
            end else begin
                v = sig >> (-k);
                x.inx = ((v << (-k)) != sig);
            end
            if (w[15]) v = -v;
            if (v > 32767 || v < -32768) begin
                x.sat = 1'b1;
                x.inx = 1'b0;
                x.w = w[15] ? 16'h8000 : 16'h7FFF;
            end else begin
                x.w = v[15:0];
            end
            if (e >= 127 && e <= 141) x.lat = ((k < 0) ? -k : k) + 1;
        end
        return x;
    endfunction

    task automatic send(input logic [15:0] w);
        int   guard;
        exp_t x;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        guard = 0;
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            chk("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        x = model(w);
        x.acc = cyc;
        last_acc = cyc;
        sb.push_back(x);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || bus.out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) chk("drain_timeout", 0, 1);
    endtask

    // Consumer: random out_ready, changed away from the sampling edge.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops on the first cycle of each result, then checks it is held.
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid) begin
                chk("in_ready_low_in_done", int'(bus.in_ready), 0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        x = sb.pop_front();
                        chk($sformatf("word[%h]", x.op), int'(bus.out_word), int'(x.w));
                        chk($sformatf("sat[%h]", x.op), int'(bus.out_sat), int'(x.sat));
                        chk($sformatf("inexact[%h]", x.op), int'(bus.out_inexact), int'(x.inx));
                        chk($sformatf("latency[%h]", x.op), cyc - x.acc, x.lat);
                    end
                    held_word = bus.out_word;
                end else begin
                    chk("word_held", int'(bus.out_word), int'(held_word));
                end
                if (bus.out_ready) consume_cyc = cyc + 1;
            end
            prev_v = bus.out_valid;
        end
    end

    logic [15:0] directed [10] = '{16'h3F80, 16'h4348, 16'hC040, 16'h3FC0, 16'h3F00,
                                   16'h0000, 16'hC700, 16'h4700, 16'h7F80, 16'hFF81};

    initial begin
        logic [7:0] e;
        bus.in_valid = 1'b0;
        bus.in_word  = 16'h0000;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_word", int'(bus.out_word), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        chk("rst_out_inexact", int'(bus.out_inexact), 0);
        reset = 1'b0;
        force_low = 1'b0;

        foreach (directed[i]) send(directed[i]);
        drain();

        // Backpressure: stall the first result while a second operand waits.
        force_low = 1'b1;
        send(16'h4348);
        fork
            send(16'hC040);
            begin
                int guard;
                guard = 0;
                while (!bus.out_valid && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                repeat (5) @(negedge clk);
                force_low = 1'b0;
            end
        join
        chk("second_accept_after_handshake", last_acc, consume_cyc + 1);
        drain();

        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 9) < 7) e = 8'($urandom_range(125, 143));
            else                          e = 8'($urandom_range(0, 255));
            send({1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))});
        end
        drain();

        // Reset two cycles into SHIFT aborts the conversion.
        force_low = 1'b0;
        send(16'h3F80);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", int'(bus.out_valid), 0);
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_out_word", int'(bus.out_word), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        send(16'h4348);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
